// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-field widths, control bit positions
// and the MEM-stage sequencer state encoding.
package pipe_pkg;

   localparam int WB_CTL_W = 2;
   localparam int M_CTL_W  = 3;

   // WB control bits
   localparam int CTL_REGWRITE = 1;
   localparam int CTL_MEMTOREG = 0;

   // MEM control bits
   localparam int CTL_BRANCH   = 2;
   localparam int CTL_MEMREAD  = 1;
   localparam int CTL_MEMWRITE = 0;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage : pipe_pkg

// File: rtl/mem_stage_latch_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_memory #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_idx,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // NOTE: the array is deliberately left out of reset; resetting it would
   // turn a RAM into DEPTH*32 reset flops.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule : data_memory

// File: rtl/mem_stage_latch.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory access with optional
// wait states, branch resolution and the MEM/WB pipeline latch.
module mem_stage_latch
   import pipe_pkg::*;
#(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter int MEM_WAIT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WB_CTL_W-1:0] wb_ctlout,
   input  logic [M_CTL_W-1:0]  m_ctlout,
   input  logic [31:0]         add_result,
   input  logic                zero,
   input  logic [31:0]         alu_result,
   input  logic [31:0]         rdata2out,
   input  logic [4:0]          five_bit_muxout,
   output logic                pcsrc,
   output logic [31:0]         branch_target,
   output logic                mem_stall,
   output logic [WB_CTL_W-1:0] memwb_ctl,
   output logic [31:0]         memwb_rdata,
   output logic [31:0]         memwb_alu,
   output logic [4:0]          memwb_dest
);

   localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
   localparam logic [3:0] WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

   mem_state_t          r_state, w_next_state;
   logic [3:0]          r_cnt, w_next_cnt;
   logic                w_op, w_stall, w_complete, w_we;
   logic [ADDR_W-1:0]   w_idx;
   logic [31:0]         w_rdata;
   logic [WB_CTL_W-1:0] r_memwb_ctl;
   logic [31:0]         r_memwb_rdata, r_memwb_alu;
   logic [4:0]          r_memwb_dest;

   assign w_op  = m_ctlout[CTL_MEMREAD] | m_ctlout[CTL_MEMWRITE];
   assign w_idx = alu_result[ADDR_W+1:2];

   // Branch resolution is independent of any memory stall.
   assign pcsrc         = m_ctlout[CTL_BRANCH] & zero;
   assign branch_target = add_result;

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // NOTE: defaults first so no path through the case leaves a comb output
   // unassigned (which would infer a latch).
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_op && HAS_WAIT) begin
               w_next_state = WAIT;
               w_next_cnt   = WAIT_INIT;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) w_next_state = IDLE;
            else               w_next_cnt   = r_cnt - 4'd1;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_stall    = 1'b0;
      w_complete = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_stall    = w_op && HAS_WAIT;
            w_complete = !(w_op && HAS_WAIT);
         end
         WAIT: begin
            w_stall    = 1'b1;
            w_complete = (r_cnt == 4'd0);
         end
         default: ;
      endcase
   end

   assign mem_stall = w_stall;

   // A reset edge aborts any pending store.
   assign w_we = w_complete & m_ctlout[CTL_MEMWRITE] & ~rst;

   data_memory #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk     (clk),
      .i_we    (w_we),
      .i_idx   (w_idx),
      .i_wdata (rdata2out),
      .o_rdata (w_rdata)
   );

   // Stall edges insert a bubble so the held instruction writes back once.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_memwb_ctl   <= '0;
         r_memwb_rdata <= 32'd0;
         r_memwb_alu   <= 32'd0;
         r_memwb_dest  <= 5'd0;
      end else if (w_complete) begin
         r_memwb_ctl   <= wb_ctlout;
         r_memwb_rdata <= w_rdata;
         r_memwb_alu   <= alu_result;
         r_memwb_dest  <= five_bit_muxout;
      end else begin
         r_memwb_ctl   <= '0;
      end
   end

   assign memwb_ctl   = r_memwb_ctl;
   assign memwb_rdata = r_memwb_rdata;
   assign memwb_alu   = r_memwb_alu;
   assign memwb_dest  = r_memwb_dest;

endmodule : mem_stage_latch

// File: tb/tb_mem_stage_latch.sv
// Bench for mem_stage_latch: three instances (MEM_WAIT = 0, 2, 3) share inputs;
// each phase checks only the instance it targets.
module tb_mem_stage_latch;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wb_ctlout;
   logic [2:0]  m_ctlout;
   logic [31:0] add_result;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2out;
   logic [4:0]  five_bit_muxout;

   logic [2:0]        w_pcsrc, w_stall;
   logic [2:0][31:0]  w_target, w_rdata, w_alu;
   logic [2:0][1:0]   w_ctl;
   logic [2:0][4:0]   w_dest;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_stage_latch #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
      .add_result(add_result), .zero(zero), .alu_result(alu_result),
      .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
      .pcsrc(w_pcsrc[0]), .branch_target(w_target[0]), .mem_stall(w_stall[0]),
      .memwb_ctl(w_ctl[0]), .memwb_rdata(w_rdata[0]), .memwb_alu(w_alu[0]),
      .memwb_dest(w_dest[0]));

   mem_stage_latch #(.MEM_WAIT(2)) dut2 (
      .clk(clk), .rst(rst), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
      .add_result(add_result), .zero(zero), .alu_result(alu_result),
      .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
      .pcsrc(w_pcsrc[1]), .branch_target(w_target[1]), .mem_stall(w_stall[1]),
      .memwb_ctl(w_ctl[1]), .memwb_rdata(w_rdata[1]), .memwb_alu(w_alu[1]),
      .memwb_dest(w_dest[1]));

   mem_stage_latch #(.MEM_WAIT(3)) dut3 (
      .clk(clk), .rst(rst), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
      .add_result(add_result), .zero(zero), .alu_result(alu_result),
      .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
      .pcsrc(w_pcsrc[2]), .branch_target(w_target[2]), .mem_stall(w_stall[2]),
      .memwb_ctl(w_ctl[2]), .memwb_rdata(w_rdata[2]), .memwb_alu(w_alu[2]),
      .memwb_dest(w_dest[2]));

   typedef struct {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] add;
      logic        zero;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  dest;
      logic        exp_pcsrc;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                        input logic z, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] dest);
      wb_ctlout       = wb;
      m_ctlout        = m;
      add_result      = add;
      zero            = z;
      alu_result      = alu;
      rdata2out       = wd;
      five_bit_muxout = dest;
   endtask

   // Leaves the bench 1 time unit after a reset edge, rst low, no memory op.
   task automatic do_reset();
      rst      = 1'b1;
      m_ctlout = 3'b000;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      // wb, m, add, zero, alu, wdata, dest, exp_pcsrc, chk_rdata, exp_rdata
      vecs[0] = '{2'b00, 3'b001, 32'h0,  1'b0, 32'h010, 32'hDEADBEEF, 5'd3,  1'b0, 1'b0, 32'h0};
      vecs[1] = '{2'b11, 3'b010, 32'h0,  1'b0, 32'h010, 32'h0,        5'd7,  1'b0, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{2'b00, 3'b001, 32'h0,  1'b0, 32'h400, 32'h12345678, 5'd0,  1'b0, 1'b0, 32'h0};
      vecs[3] = '{2'b11, 3'b010, 32'h0,  1'b0, 32'h000, 32'h0,        5'd8,  1'b0, 1'b1, 32'h12345678};
      vecs[4] = '{2'b11, 3'b010, 32'h0,  1'b0, 32'h403, 32'h0,        5'd9,  1'b0, 1'b1, 32'h12345678};
      vecs[5] = '{2'b01, 3'b011, 32'h0,  1'b0, 32'h010, 32'hCAFEF00D, 5'd10, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[6] = '{2'b11, 3'b010, 32'h0,  1'b0, 32'h010, 32'h0,        5'd11, 1'b0, 1'b1, 32'hCAFEF00D};
      vecs[7] = '{2'b00, 3'b100, 32'h40, 1'b1, 32'h010, 32'h0,        5'd0,  1'b1, 1'b1, 32'hCAFEF00D};
      vecs[8] = '{2'b00, 3'b100, 32'h80, 1'b0, 32'h014, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0};
      vecs[9] = '{2'b10, 3'b000, 32'h44, 1'b1, 32'h810, 32'h0,        5'd12, 1'b0, 1'b1, 32'hCAFEF00D};

      // Reset with nonzero (branch, no memory op) inputs held for 2 edges
      rst = 1'b1;
      drive(2'b11, 3'b100, 32'h55, 1'b1, 32'h1234, 32'hFFFF, 5'd31);
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_ctl%0d", d),   32'(w_ctl[d]),   32'h0);
         check($sformatf("rst_rdata%0d", d), w_rdata[d],     32'h0);
         check($sformatf("rst_alu%0d", d),   w_alu[d],       32'h0);
         check($sformatf("rst_dest%0d", d),  32'(w_dest[d]),  32'h0);
         check($sformatf("rst_stall%0d", d), 32'(w_stall[d]), 32'h0);
      end
      check("rst_pcsrc", 32'(w_pcsrc[0]), 32'h1);
      check("rst_target", w_target[0], 32'h55);
      zero = 1'b0;
      #1 check("rst_pcsrc_z0", 32'(w_pcsrc[0]), 32'h0);
      rst = 1'b0;

      // MEM_WAIT=0: one instruction per cycle, checked against the table
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].wb, vecs[i].m, vecs[i].add, vecs[i].zero, vecs[i].alu,
               vecs[i].wdata, vecs[i].dest);
         #1;
         check($sformatf("v%0d_pcsrc", i),  32'(w_pcsrc[0]), 32'(vecs[i].exp_pcsrc));
         check($sformatf("v%0d_target", i), w_target[0],     vecs[i].add);
         check($sformatf("v%0d_stall", i),  32'(w_stall[0]), 32'h0);
         @(posedge clk); #1;
         check($sformatf("v%0d_ctl", i),  32'(w_ctl[0]),  32'(vecs[i].wb));
         check($sformatf("v%0d_alu", i),  w_alu[0],       vecs[i].alu);
         check($sformatf("v%0d_dest", i), 32'(w_dest[0]), 32'(vecs[i].dest));
         if (vecs[i].chk_rdata)
            check($sformatf("v%0d_rdata", i), w_rdata[0], vecs[i].exp_rdata);
      end

      // MEM_WAIT=2: store, then a load that stalls for exactly 3 cycles
      do_reset();
      drive(2'b00, 3'b001, 32'h0, 1'b0, 32'h30, 32'h5A5A0001, 5'd2);
      repeat (3) @(posedge clk);
      #1;
      check("w2_store_dest", 32'(w_dest[1]), 32'd2);
      m_ctlout = 3'b000;
      #1 check("w2_idle_stall", 32'(w_stall[1]), 32'h0);
      drive(2'b11, 3'b010, 32'h0, 1'b0, 32'h30, 32'h0, 5'd9);
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("w2_stall_c%0d", k), 32'(w_stall[1]), 32'h1);
         @(posedge clk); #1;
         if (k < 2) begin
            check($sformatf("w2_bubble_ctl%0d", k),  32'(w_ctl[1]),  32'h0);
            check($sformatf("w2_bubble_dest%0d", k), 32'(w_dest[1]), 32'd2);
         end else begin
            check("w2_load_ctl",   32'(w_ctl[1]),  32'h3);
            check("w2_load_rdata", w_rdata[1],     32'h5A5A0001);
            check("w2_load_dest",  32'(w_dest[1]), 32'd9);
         end
      end
      m_ctlout = 3'b000;
      #1 check("w2_stall_drop", 32'(w_stall[1]), 32'h0);

      // MEM_WAIT=3: pre-write 0, then reset in the 2nd stall cycle of a store
      do_reset();
      drive(2'b00, 3'b001, 32'h0, 1'b0, 32'h20, 32'h0, 5'd0);
      repeat (4) @(posedge clk);
      #1;
      m_ctlout = 3'b000;
      #1 check("w3_prewrite_idle", 32'(w_stall[2]), 32'h0);
      @(posedge clk); #1;
      drive(2'b00, 3'b001, 32'h0, 1'b0, 32'h20, 32'hAAAA5555, 5'd0);
      #1 check("w3_stall_c0", 32'(w_stall[2]), 32'h1);
      @(posedge clk); #1;
      check("w3_stall_c1", 32'(w_stall[2]), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      m_ctlout = 3'b000;
      #1;
      check("w3_abort_stall", 32'(w_stall[2]), 32'h0);
      check("w3_abort_ctl",   32'(w_ctl[2]),   32'h0);
      drive(2'b11, 3'b010, 32'h0, 1'b0, 32'h20, 32'h0, 5'd5);
      repeat (4) @(posedge clk);
      #1;
      check("w3_load_ctl",   32'(w_ctl[2]),  32'h3);
      check("w3_load_rdata", w_rdata[2],     32'h0);
      check("w3_load_dest",  32'(w_dest[2]), 32'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_mem_stage_latch

// File: doc/mem_stage_latch.md
Name: mem_stage_latch

Overview:
- Consumer end of the EX/MEM pipeline latch in the 5-stage MIPS pipeline.
- Takes the EX/MEM outputs and performs the data-memory access (load/store), with an optional wait-state sequencer that stalls the pipeline.
- Resolves the branch decision (PCSrc).
- Drives the MEM/WB pipeline latch consumed by the write-back stage.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of 2).
- ADDR_W, 8, log2(DEPTH); word-index width.
- MEM_WAIT, 0, extra wait cycles per load/store (0 = single-cycle access), max 15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wb_ctlout  input  2  WB controls from EX/MEM: [1]=regwrite, [0]=memtoreg
- m_ctlout  input  3  MEM controls: [2]=branch, [1]=memread, [0]=memwrite
- add_result  input  32  branch target from EX/MEM
- zero  input  1  ALU zero flag
- alu_result  input  32  ALU result / memory byte address
- rdata2out  input  32  store data
- five_bit_muxout  input  5  destination register number
- pcsrc  output  1  branch taken = m_ctlout[2] & zero (combinational)
- branch_target  output  32  add_result pass-through (combinational)
- mem_stall  output  1  high while a multi-cycle access is pending; upstream holds EX/MEM and PC
- memwb_ctl  output  2  registered WB controls
- memwb_rdata  output  32  registered load data
- memwb_alu  output  32  registered alu_result
- memwb_dest  output  5  registered destination register

Behaviour:
- Reset (clk edge with rst=1): memwb_ctl=0, memwb_rdata=0, memwb_alu=0, memwb_dest=0, state=IDLE, wait counter=0, mem_stall=0. Memory contents are not reset.
- Reset mid-access: sequencer aborts to IDLE and the pending store is not written.
- Address: word index = alu_result[ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits are truncated, so addresses wrap modulo DEPTH.
- Access type:
  - op = memread | memwrite.
  - memread and memwrite both set: treated as a store. memwb_rdata captures the pre-write word.
- States:
  - IDLE: default state.
    - If op && MEM_WAIT>0: go to WAIT, counter=MEM_WAIT-1, mem_stall=1 (combinational from state/op).
    - Otherwise the access completes this edge.
  - WAIT: mem_stall=1.
    - Counter decrements each cycle.
    - At counter==0: access completes on that edge, go to IDLE. mem_stall drops the following cycle.
- Completion edge:
  - If memwrite: mem[idx] <= rdata2out.
  - MEM/WB latch loads:
    - memwb_ctl <= wb_ctlout
    - memwb_rdata <= mem[idx] (old value)
    - memwb_alu <= alu_result
    - memwb_dest <= five_bit_muxout
- Non-memory instruction (op=0): completes every edge. memwb_rdata <= mem[idx] is harmless and undefined-free.
- Stall cycles (WAIT, or IDLE edge that enters WAIT): MEM/WB loads a bubble (memwb_ctl <= 0, other fields hold). This prevents a duplicate writeback.
- Latency:
  - MEM/WB valid 1 edge after inputs when MEM_WAIT=0.
  - MEM_WAIT+1 edges when op=1 and MEM_WAIT>0.
  - A store occupies MEM_WAIT+1 cycles total.
- Input stability: inputs are required stable while mem_stall=1. Changes during WAIT are sampled only at the completion edge.
- pcsrc/branch_target: purely combinational and never gated by stall. Branches carry op=0 and so never stall.
- Back-to-back loads/stores (MEM_WAIT=0): one per cycle, no bubbles. A load of an address stored the prior cycle returns the new data.

Decomposition:
- Shared package pipe_pkg holds:
  - Bit-index constants: CTL_REGWRITE=1, CTL_MEMTOREG=0, CTL_BRANCH=2, CTL_MEMREAD=1, CTL_MEMWRITE=0.
  - mem state encoding IDLE/WAIT.
  - Control field widths (2, 3).
- One sub-module: data_memory (DEPTH×32 array, synchronous write, asynchronous read, word-index port).
- Sequencer and MEM/WB latch stay in mem_stage_latch.

Test Plan:
- Reset: drive rst=1 for 2 cycles with nonzero inputs -> all memwb_* = 0, mem_stall=0, pcsrc follows inputs.
- Store then load, MEM_WAIT=0:
  - Cycle 1: m_ctlout=3'b001, alu_result=0x10, rdata2out=0xDEADBEEF.
  - Cycle 2: m_ctlout=3'b010, wb_ctlout=2'b11, alu_result=0x10, five_bit_muxout=7.
  - Expect after cycle 2 edge: memwb_rdata=0xDEADBEEF, memwb_ctl=2'b11, memwb_dest=7.
- Branch: m_ctlout=3'b100, zero=1, add_result=0x40 -> pcsrc=1, branch_target=0x40. With zero=0 -> pcsrc=0.
- Wrap, DEPTH=256:
  - Store 0x12345678 at alu_result=0x400.
  - Load alu_result=0x000 -> memwb_rdata=0x12345678.
  - alu_result=0x403 load -> same word.
- MEM_WAIT=2 load:
  - Expect mem_stall=1 for exactly 3 cycles.
  - memwb_ctl=0 on the first 2 edges.
  - Loaded data and wb_ctlout appear on the 3rd edge.
- Reset mid-WAIT (MEM_WAIT=3):
  - Store 0xAAAA5555 to 0x20, assert rst on 2nd stall cycle.
  - Expect state IDLE, mem_stall=0.
  - A subsequent load of 0x20 returns the prior value 0x00000000 (bench pre-writes 0).
